breadboard: RTL and testbench

BREADBOARD -- requirements
Module: breadboard

---
 rtl/breadboard_pkg.sv | 28 ++
 rtl/alu_decode.sv | 25 ++
 rtl/breadboard.sv | 47 ++++
 tb/tb_breadboard.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/breadboard_pkg.sv
// breadboard_pkg: opcodes, select bit indices and data width shared by breadboard and alu_decode
package breadboard_pkg;
  localparam int DW = 16;
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOT   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NAND  = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_XNOR  = 4'b0110;
  localparam logic [3:0] OP_ADD   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_SHR   = 4'b1010;
  localparam logic [3:0] OP_SHL   = 4'b1011;
  localparam logic [3:0] OP_CLEAR = 4'b1111;
  localparam int SEL_ADD   = 0;
  localparam int SEL_SHR   = 1;
  localparam int SEL_SHL   = 2;
  localparam int SEL_AND   = 3;
  localparam int SEL_OR    = 4;
  localparam int SEL_XOR   = 5;
  localparam int SEL_XNOR  = 6;
  localparam int SEL_NAND  = 7;
  localparam int SEL_SUB   = 8;
  localparam int SEL_NOR   = 9;
  localparam int SEL_NOT   = 10;
  localparam int SEL_CLEAR = 11;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational opcode -> one-hot select; ports opcode in, select out (undefined opcodes map to CLEAR)
module alu_decode
  import breadboard_pkg::*;
(
  input  logic [3:0]  opcode,
  output logic [11:0] select
);
  always_comb begin
    select = '0;
    case (opcode)
      OP_ADD:  select[SEL_ADD]   = 1'b1;
      OP_SHR:  select[SEL_SHR]   = 1'b1;
      OP_SHL:  select[SEL_SHL]   = 1'b1;
      OP_AND:  select[SEL_AND]   = 1'b1;
      OP_OR:   select[SEL_OR]    = 1'b1;
      OP_XOR:  select[SEL_XOR]   = 1'b1;
      OP_XNOR: select[SEL_XNOR]  = 1'b1;
      OP_NAND: select[SEL_NAND]  = 1'b1;
      OP_SUB:  select[SEL_SUB]   = 1'b1;
      OP_NOR:  select[SEL_NOR]   = 1'b1;
      OP_NOT:  select[SEL_NOT]   = 1'b1;
      default: select[SEL_CLEAR] = 1'b1;
    endcase
  end
endmodule

// File: rtl/breadboard.sv
// breadboard: 16-bit one-cycle ALU accumulator; ports clk, rst, a, b, opcode in; select, result, carry, overflow out; flags built only with BREADBOARD_STATUS_FLAGS_EN
module breadboard
  import breadboard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    opcode,
  output logic [11:0]   select,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          overflow
);
  logic [DW-1:0] bop, sum, nxt;
  logic sub;
  alu_decode u_dec (.opcode(opcode), .select(select));
  assign sub = select[SEL_SUB];
  assign bop = sub ? ~b : b;
  always_comb begin
    nxt = select[SEL_AND]  ? a & b :
          select[SEL_OR]   ? a | b :
          select[SEL_NOT]  ? ~a :
          select[SEL_XOR]  ? a ^ b :
          select[SEL_NAND] ? ~(a & b) :
          select[SEL_NOR]  ? ~(a | b) :
          select[SEL_XNOR] ? ~(a ^ b) :
          select[SEL_SHR]  ? {1'b0, a[DW-1:1]} :
          select[SEL_SHL]  ? {a[DW-2:0], 1'b0} :
          (select[SEL_ADD] | sub) ? sum : '0;
  end
  always_ff @(posedge clk)
    result <= rst ? '0 : nxt;
`ifdef BREADBOARD_STATUS_FLAGS_EN
  logic cout;
  assign {cout, sum} = {1'b0, a} + {1'b0, bop} + {{DW{1'b0}}, sub};
  // overflow: same-sign a and (possibly inverted) b, result sign differs
  always_ff @(posedge clk) begin
    carry    <= !rst && (select[SEL_ADD] | sub) && cout;
    overflow <= !rst && (select[SEL_ADD] | sub) && (a[DW-1] == bop[DW-1]) && (sum[DW-1] != a[DW-1]);
  end
`else
  assign sum      = a + bop + {{(DW-1){1'b0}}, sub};
  assign carry    = 1'b0;
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_breadboard.sv
// tb_breadboard: directed + model-checked bench for breadboard
module tb_breadboard;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] a, b;
  logic [3:0] opcode;
  logic [11:0] select;
  logic [15:0] result;
  logic carry, overflow;
  int checks = 0;
  int failures = 0;
`ifdef BREADBOARD_STATUS_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  breadboard dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .opcode(opcode),
    .select(select), .result(result), .carry(carry), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [17:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    int ux, uy, sx, sy, r, s;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = x[15] ? ux - 65536 : ux;
    sy = y[15] ? uy - 65536 : uy;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      4'd0:  r = ux & uy;
      4'd1:  r = ux | uy;
      4'd2:  r = ~ux;
      4'd3:  r = ux ^ uy;
      4'd4:  r = ~(ux & uy);
      4'd5:  r = ~(ux | uy);
      4'd6:  r = ~(ux ^ uy);
      4'd8:  begin r = ux + uy; c = r > 65535; s = sx + sy; v = s > 32767 || s < -32768; end
      4'd9:  begin r = ux - uy; c = ux >= uy; s = sx - sy; v = s > 32767 || s < -32768; end
      4'd10: r = ux / 2;
      4'd11: r = ux * 2;
      default: r = 0;
    endcase
    return {c & FL, v & FL, r[15:0]};
  endfunction
  function automatic logic [11:0] sel_of(input logic [3:0] op);
    int i;
    case (op)
      4'd8: i = 0; 4'd10: i = 1; 4'd11: i = 2; 4'd0: i = 3;
      4'd1: i = 4; 4'd3: i = 5;  4'd6: i = 6;  4'd4: i = 7;
      4'd9: i = 8; 4'd5: i = 9;  4'd2: i = 10; default: i = 11;
    endcase
    return 12'd1 << i;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  logic [17:0] m;
  bit live = 1'b0;
  always @(posedge clk) begin
    m <= rst ? 18'd0 : model(opcode, a, b);
    live <= 1'b1;
  end
  always @(negedge clk) begin
    chk("select", {20'd0, select}, {20'd0, sel_of(opcode)});
    if (live) begin
      chk("model_result", {16'd0, result}, {16'd0, m[15:0]});
      chk("model_carry", {31'd0, carry}, {31'd0, m[17]});
      chk("model_overflow", {31'd0, overflow}, {31'd0, m[16]});
    end
  end
  task automatic op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                    input logic [15:0] er, input logic ec, input logic ev, input string n);
    opcode = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    chk({n, "_result"}, {16'd0, result}, {16'd0, er});
    chk({n, "_carry"}, {31'd0, carry}, {31'd0, ec & FL});
    chk({n, "_overflow"}, {31'd0, overflow}, {31'd0, ev & FL});
    @(negedge clk);
  endtask
  logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd8};
  logic [17:0] e;
  initial begin
    rst = 1'b1;
    opcode = 4'hF;
    a = 16'h1234;
    b = 16'h5678;
    repeat (2) @(negedge clk);
    chk("reset_result", {16'd0, result}, 32'h0);
    chk("reset_carry", {31'd0, carry}, 32'h0);
    chk("reset_overflow", {31'd0, overflow}, 32'h0);
    chk("reset_select", {20'd0, select}, 32'h800);
    rst = 1'b0;
    op(4'hF, 16'h0000, 16'h0000, 16'h0000, 0, 0, "idle_clear");
    op(4'd0, 16'h000A, 16'h0003, 16'h0002, 0, 0, "and");
    op(4'd1, 16'h0003, 16'h0001, 16'h0003, 0, 0, "or");
    op(4'd5, 16'h0003, 16'h0001, 16'hFFFC, 0, 0, "nor");
    op(4'd2, 16'h4002, 16'hFFFF, 16'hBFFD, 0, 0, "not");
    op(4'd3, 16'h4002, 16'h0003, 16'h4001, 0, 0, "xor");
    op(4'd6, 16'h0006, 16'h0003, 16'hFFFA, 0, 0, "xnor");
    op(4'd4, 16'h00F0, 16'h0FF0, 16'hFF0F, 0, 0, "nand");
    op(4'd10, 16'h0002, 16'hFFFF, 16'h0001, 0, 0, "shr");
    op(4'd11, 16'h0002, 16'h0000, 16'h0004, 0, 0, "shl");
    op(4'd11, 16'h8001, 16'h0000, 16'h0002, 0, 0, "shl_msb");
    op(4'd8, 16'h0002, 16'h0003, 16'h0005, 0, 0, "add");
    op(4'd9, 16'h0006, 16'h0003, 16'h0003, 1, 0, "sub");
    op(4'd8, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, "add_ovf");
    op(4'd8, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, "add_carry");
    op(4'd9, 16'h0003, 16'h0006, 16'hFFFD, 0, 0, "sub_borrow");
    op(4'd9, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, "sub_ovf");
    op(4'd8, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, "pre_flag");
    op(4'd0, 16'hFFFF, 16'h00FF, 16'h00FF, 0, 0, "flags_cleared");
    op(4'd7, 16'h1234, 16'h4321, 16'h0000, 0, 0, "undef_0111");
    for (int i = 0; i < 12; i++) begin
      a = 16'h8000 ^ 16'(i * 16'h1357);
      b = 16'h7FFF ^ 16'(i * 16'h0F0F);
      e = model(ops[i], a, b);
      op(ops[i], a, b, e[15:0], e[17], e[16], "alt_op");
      op((i % 2) ? 4'hF : 4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, "alt_clear");
    end
    op(4'd1, 16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, "pre_rst");
    rst = 1'b1;
    op(4'd8, 16'h0002, 16'h0003, 16'h0000, 0, 0, "rst_add");
    rst = 1'b0;
    op(4'd8, 16'h0002, 16'h0003, 16'h0005, 0, 0, "post_rst_add");
    repeat (60) begin
      opcode = 4'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
